// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: symbols, board size, controller states and winning lines.
package ttt_pkg;

  localparam logic SYM_X = 1'b1;
  localparam logic SYM_O = 1'b0;

  localparam int unsigned N_CELLS = 9;
  localparam int unsigned N_LINES = 8;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StCheck,
    StCommit,
    StSettle,
    StGameOver
  } state_e;

  typedef logic [3:0] cell_idx_t;

  // Rows, columns, then the two diagonals (row-major cell indices).
  localparam cell_idx_t LINE_TBL [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector over the board cell outputs.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [N_CELLS-1:0] i_cell_valid,
  input  logic [N_CELLS-1:0] i_cell_symbol,
  output logic               o_win,
  output logic               o_win_symbol
);

  logic w_hit;
  logic w_hit_symbol;

  always_comb begin
    w_hit        = 1'b0;
    w_hit_symbol = 1'b0;
    for (int l = 0; l < int'(N_LINES); l++) begin
      if (!w_hit &&
          i_cell_valid[LINE_TBL[l][0]] &&
          i_cell_valid[LINE_TBL[l][1]] &&
          i_cell_valid[LINE_TBL[l][2]] &&
          (i_cell_symbol[LINE_TBL[l][0]] == i_cell_symbol[LINE_TBL[l][1]]) &&
          (i_cell_symbol[LINE_TBL[l][1]] == i_cell_symbol[LINE_TBL[l][2]])) begin
        w_hit        = 1'b1;
        w_hit_symbol = i_cell_symbol[LINE_TBL[l][0]];
      end
    end
  end

  assign o_win        = w_hit;
  assign o_win_symbol = w_hit_symbol;

endmodule

// File: rtl/ttt_move_ctrl.sv
// Turn/move controller: validates move requests against cell occupancy, pulses the cell set,
// tracks turn and move count, and detects win/draw after each committed move.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter logic        FIRST_SYMBOL = 1'b1,
  parameter int unsigned N_CELLS      = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_new_game,
  input  logic               i_move_req,
  input  logic [3:0]         i_move_pos,
  input  logic [N_CELLS-1:0] i_cell_valid,
  input  logic [N_CELLS-1:0] i_cell_symbol,
  output logic               o_ready,
  output logic [N_CELLS-1:0] o_cell_set,
  output logic               o_set_symbol,
  output logic               o_cell_clr,
  output logic               o_move_ack,
  output logic               o_move_err,
  output logic               o_turn,
  output logic [3:0]         o_move_count,
  output logic               o_game_over,
  output logic               o_winner_valid,
  output logic               o_winner_symbol,
  output logic               o_draw
);

  state_e     r_state_q, w_state_d;
  logic [3:0] r_pos_q, w_pos_d;
  logic       r_turn_q, w_turn_d;
  logic [3:0] r_count_q, w_count_d;
  logic       r_win_v_q, w_win_v_d;
  logic       r_win_s_q, w_win_s_d;
  logic       r_draw_q, w_draw_d;

  logic        w_win;
  logic        w_win_symbol;
  logic [15:0] w_valid_ext;
  logic        w_illegal;

  ttt_line_check u_line_check (
    .i_cell_valid  (i_cell_valid),
    .i_cell_symbol (i_cell_symbol),
    .o_win         (w_win),
    .o_win_symbol  (w_win_symbol)
  );

  // Zero-extended so out-of-range positions index safely; they are rejected anyway.
  assign w_valid_ext = {7'd0, i_cell_valid};
  assign w_illegal   = (r_pos_q > 4'd8) || w_valid_ext[r_pos_q];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state_q <= StClear;
      r_pos_q   <= 4'd0;
      r_turn_q  <= FIRST_SYMBOL;
      r_count_q <= 4'd0;
      r_win_v_q <= 1'b0;
      r_win_s_q <= 1'b0;
      r_draw_q  <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_pos_q   <= w_pos_d;
      r_turn_q  <= w_turn_d;
      r_count_q <= w_count_d;
      r_win_v_q <= w_win_v_d;
      r_win_s_q <= w_win_s_d;
      r_draw_q  <= w_draw_d;
    end
  end

  always_comb begin
    w_state_d  = r_state_q;
    w_pos_d    = r_pos_q;
    w_turn_d   = r_turn_q;
    w_count_d  = r_count_q;
    w_win_v_d  = r_win_v_q;
    w_win_s_d  = r_win_s_q;
    w_draw_d   = r_draw_q;
    o_cell_set = '0;
    o_move_ack = 1'b0;
    o_move_err = 1'b0;

    unique case (r_state_q)
      StClear: w_state_d = StIdle;
      StIdle: begin
        if (i_move_req) begin
          w_pos_d   = i_move_pos;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        if (w_illegal) begin
          o_move_err = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_state_d = StCommit;
        end
      end
      StCommit: begin
        o_cell_set = N_CELLS'(1) << r_pos_q;
        w_state_d  = StSettle;
      end
      StSettle: begin
        o_move_ack = 1'b1;
        w_count_d  = r_count_q + 4'd1;
        if (w_win) begin
          w_win_v_d = 1'b1;
          w_win_s_d = w_win_symbol;
          w_state_d = StGameOver;
        end else if (r_count_q == 4'd8) begin
          w_draw_d  = 1'b1;
          w_state_d = StGameOver;
        end else begin
          w_turn_d  = ~r_turn_q;
          w_state_d = StIdle;
        end
      end
      StGameOver: w_state_d = StGameOver;
      default:    w_state_d = StClear;
    endcase

    // New game wins over everything, including a pulse due in this very cycle.
    if (i_new_game) begin
      w_state_d  = StClear;
      w_turn_d   = FIRST_SYMBOL;
      w_count_d  = 4'd0;
      w_win_v_d  = 1'b0;
      w_win_s_d  = 1'b0;
      w_draw_d   = 1'b0;
      o_cell_set = '0;
      o_move_ack = 1'b0;
      o_move_err = 1'b0;
    end
  end

  assign o_ready         = (r_state_q == StIdle);
  assign o_cell_clr      = (r_state_q == StClear);
  assign o_game_over     = (r_state_q == StGameOver);
  assign o_set_symbol    = r_turn_q;
  assign o_turn          = r_turn_q;
  assign o_move_count    = r_count_q;
  assign o_winner_valid  = r_win_v_q;
  assign o_winner_symbol = r_win_s_q;
  assign o_draw          = r_draw_q;

endmodule
